// File: rtl/rx_mac.sv
// XGMII (32-bit) to AXI-Stream receive MAC: strips preamble/SFD and FCS, checks CRC-32.
// Payload word sampled at edge n appears after edge n+3; no backpressure, every beat must be taken.
module rx_mac #(
    parameter int XGMII_DATA_WIDTH = 32,
    parameter int XGMII_DATA_BYTES = 4,
    parameter int AXIS_DATA_WIDTH  = 32,
    parameter int AXIS_DATA_BYTES  = 4
) (
    input  logic                        rx_clk,
    input  logic                        rx_rst,
    input  logic [XGMII_DATA_WIDTH-1:0] in_xgmii_data,
    input  logic [XGMII_DATA_BYTES-1:0] in_xgmii_ctl,
    output logic [AXIS_DATA_WIDTH-1:0]  out_master_rx_tdata,
    output logic [AXIS_DATA_BYTES-1:0]  out_master_rx_tkeep,
    output logic                        out_master_rx_tvalid,
    output logic                        out_master_rx_tlast,
    output logic                        out_master_rx_tuser
);

    localparam int NB = XGMII_DATA_BYTES;
    localparam int KW = $clog2(NB);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PREAMBLE = 2'd1;
    localparam logic [1:0] ST_DATA     = 2'd2;
    localparam logic [1:0] ST_DROP     = 2'd3;

    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    logic [1:0]                  state_q, state_d;
    logic [XGMII_DATA_WIDTH-1:0] in_dat_q, in_dat_d;
    logic [NB-1:0]               in_ctl_q, in_ctl_d;
    logic [XGMII_DATA_WIDTH-1:0] sr0_q, sr0_d, sr1_q, sr1_d;
    logic                        sr0_vld_q, sr0_vld_d, sr1_vld_q, sr1_vld_d;
    logic [31:0]                 crc_q, crc_d;
    logic                        err_q, err_d;
    logic                        pend_vld_q, pend_vld_d;
    logic [AXIS_DATA_WIDTH-1:0]  pend_dat_q, pend_dat_d;
    logic [AXIS_DATA_BYTES-1:0]  pend_keep_q, pend_keep_d;
    logic                        pend_user_q, pend_user_d;
    logic [AXIS_DATA_WIDTH-1:0]  tdata_q, tdata_d;
    logic [AXIS_DATA_BYTES-1:0]  tkeep_q, tkeep_d;
    logic                        tvalid_q, tvalid_d;
    logic                        tlast_q, tlast_d;
    logic                        tuser_q, tuser_d;

    logic [NB-1:0]              term_hit, start_hit, idle_hit;
    logic [KW-1:0]              term_k;
    logic                       below_ctl;
    logic [AXIS_DATA_BYTES-1:0] keep_k;
    logic [31:0]                crc_acc, crc_term;
    logic                       start_word_ok, sfd_ok, user_end;

    // Lane decode, terminate position and the CRC both at the terminate lane and over the full word.
    always_comb begin
        term_hit  = '0;
        start_hit = '0;
        idle_hit  = '0;
        for (int l = 0; l < NB; l++) begin
            term_hit[l]  = in_ctl_q[l] && (in_dat_q[8*l +: 8] == 8'hFD);
            start_hit[l] = in_ctl_q[l] && (in_dat_q[8*l +: 8] == 8'hFB);
            idle_hit[l]  = in_ctl_q[l] && (in_dat_q[8*l +: 8] == 8'h07);
        end
        term_k = '0;
        for (int l = NB - 1; l >= 0; l--) begin
            if (term_hit[l]) term_k = KW'(l);
        end
        below_ctl = 1'b0;
        keep_k    = '0;
        crc_acc   = crc_q;
        crc_term  = crc_q;
        for (int l = 0; l < NB; l++) begin
            if (l < int'(term_k)) begin
                below_ctl = below_ctl | in_ctl_q[l];
                keep_k[l] = 1'b1;
            end
            if (l == int'(term_k)) crc_term = crc_acc;
            crc_acc = crc_byte(crc_acc, in_dat_q[8*l +: 8]);
        end
        start_word_ok = (in_ctl_q == NB'(1)) && (in_dat_q == 32'h555555FB);
        sfd_ok        = (in_ctl_q == '0) && (in_dat_q == 32'hD5555555);
        user_end      = err_q | below_ctl | (crc_term != CRC_RESIDUE);
    end

    always_comb begin
        state_d     = state_q;
        in_dat_d    = in_xgmii_data;
        in_ctl_d    = in_xgmii_ctl;
        sr0_d       = sr0_q;
        sr1_d       = sr1_q;
        sr0_vld_d   = sr0_vld_q;
        sr1_vld_d   = sr1_vld_q;
        crc_d       = crc_q;
        err_d       = err_q;
        pend_vld_d  = 1'b0;
        pend_dat_d  = pend_dat_q;
        pend_keep_d = pend_keep_q;
        pend_user_d = pend_user_q;
        tdata_d     = '0;
        tkeep_d     = '0;
        tvalid_d    = 1'b0;
        tlast_d     = 1'b0;
        tuser_d     = 1'b0;

        // A deferred final beat never collides with a DATA-state beat: it follows a frame end.
        if (pend_vld_q) begin
            tvalid_d = 1'b1;
            tdata_d  = pend_dat_q;
            tkeep_d  = pend_keep_q;
            tlast_d  = 1'b1;
            tuser_d  = pend_user_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_word_ok) begin
                    state_d = ST_PREAMBLE;
                    err_d   = 1'b0;
                    crc_d   = 32'hFFFFFFFF;
                end
            end
            ST_PREAMBLE: begin
                state_d   = sfd_ok ? ST_DATA : ST_DROP;
                sr0_vld_d = 1'b0;
                sr1_vld_d = 1'b0;
            end
            ST_DROP: begin
                if (|(term_hit | idle_hit)) state_d = ST_IDLE;
            end
            default: begin
                if (|term_hit) begin
                    state_d   = ST_IDLE;
                    sr0_vld_d = 1'b0;
                    sr1_vld_d = 1'b0;
                    if (term_k == '0) begin
                        // The word just before terminate is all FCS.
                        if (sr1_vld_q) begin
                            tvalid_d = 1'b1;
                            tdata_d  = sr1_q;
                            tkeep_d  = '1;
                            tlast_d  = 1'b1;
                            tuser_d  = user_end;
                        end
                    end else begin
                        if (sr1_vld_q) begin
                            tvalid_d = 1'b1;
                            tdata_d  = sr1_q;
                            tkeep_d  = '1;
                        end
                        if (sr0_vld_q) begin
                            pend_vld_d  = 1'b1;
                            pend_dat_d  = sr0_q;
                            pend_keep_d = keep_k;
                            pend_user_d = user_end;
                        end
                    end
                end else if (|start_hit) begin
                    sr0_vld_d = 1'b0;
                    sr1_vld_d = 1'b0;
                    if (sr1_vld_q) begin
                        tvalid_d = 1'b1;
                        tdata_d  = sr1_q;
                        tkeep_d  = '1;
                    end
                    if (sr0_vld_q) begin
                        pend_vld_d  = 1'b1;
                        pend_dat_d  = sr0_q;
                        pend_keep_d = '1;
                        pend_user_d = 1'b1;
                    end
                    if (start_word_ok) begin
                        state_d = ST_PREAMBLE;
                        err_d   = 1'b0;
                        crc_d   = 32'hFFFFFFFF;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    // Words carrying stray control lanes stay in the stream so latency is unchanged.
                    if (|in_ctl_q) err_d = 1'b1;
                    sr0_d     = in_dat_q;
                    sr1_d     = sr0_q;
                    sr0_vld_d = 1'b1;
                    sr1_vld_d = sr0_vld_q;
                    crc_d     = crc_acc;
                    if (sr1_vld_q) begin
                        tvalid_d = 1'b1;
                        tdata_d  = sr1_q;
                        tkeep_d  = '1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state_q     <= ST_IDLE;
            in_dat_q    <= '0;
            in_ctl_q    <= '0;
            sr0_q       <= '0;
            sr1_q       <= '0;
            sr0_vld_q   <= 1'b0;
            sr1_vld_q   <= 1'b0;
            crc_q       <= '0;
            err_q       <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_dat_q  <= '0;
            pend_keep_q <= '0;
            pend_user_q <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_dat_q    <= in_dat_d;
            in_ctl_q    <= in_ctl_d;
            sr0_q       <= sr0_d;
            sr1_q       <= sr1_d;
            sr0_vld_q   <= sr0_vld_d;
            sr1_vld_q   <= sr1_vld_d;
            crc_q       <= crc_d;
            err_q       <= err_d;
            pend_vld_q  <= pend_vld_d;
            pend_dat_q  <= pend_dat_d;
            pend_keep_q <= pend_keep_d;
            pend_user_q <= pend_user_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
        end
    end

    assign out_master_rx_tdata  = tdata_q;
    assign out_master_rx_tkeep  = tkeep_q;
    assign out_master_rx_tvalid = tvalid_q;
    assign out_master_rx_tlast  = tlast_q;
    assign out_master_rx_tuser  = tuser_q;

endmodule

// File: tb/tb_rx_mac.sv
// Bench for rx_mac: frame table, back-to-back, mid-frame reset and random frames against a byte-level model.
module tb_rx_mac;

    logic        rx_clk = 1'b0;
    logic        rx_rst;
    logic [31:0] in_xgmii_data;
    logic [3:0]  in_xgmii_ctl;
    logic [31:0] out_master_rx_tdata;
    logic [3:0]  out_master_rx_tkeep;
    logic        out_master_rx_tvalid;
    logic        out_master_rx_tlast;
    logic        out_master_rx_tuser;

    rx_mac dut (
        .rx_clk               (rx_clk),
        .rx_rst               (rx_rst),
        .in_xgmii_data        (in_xgmii_data),
        .in_xgmii_ctl         (in_xgmii_ctl),
        .out_master_rx_tdata  (out_master_rx_tdata),
        .out_master_rx_tkeep  (out_master_rx_tkeep),
        .out_master_rx_tvalid (out_master_rx_tvalid),
        .out_master_rx_tlast  (out_master_rx_tlast),
        .out_master_rx_tuser  (out_master_rx_tuser)
    );

    always #5 rx_clk = ~rx_clk;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [31:0] dat;
        logic [3:0]  keep;
        logic        last;
        logic        user;
        int          cyc;
    } beat_t;

    typedef struct {
        int         len;
        bit         bad_fcs;
        int         err_word;
        bit         bad_pre;
        int         exp_beats;
        logic [3:0] exp_keep;
        logic       exp_user;
    } tv_t;

    beat_t      exp_q[$];
    int         cyc = 0;
    int         vec_cnt = 0;
    int         err_cnt = 0;
    int         beats_seen = 0;
    logic [3:0] last_keep_seen = '0;
    logic       last_user_seen = 1'b0;

    always @(posedge rx_clk) cyc <= cyc + 1;

    always @(negedge rx_clk) begin : mon
        beat_t       e;
        logic [31:0] m;
        if (!rx_rst && out_master_rx_tvalid) begin
            beats_seen++;
            if (out_master_rx_tlast) begin
                last_keep_seen = out_master_rx_tkeep;
                last_user_seen = out_master_rx_tuser;
            end
            vec_cnt++;
            if (exp_q.size() == 0) begin
                err_cnt++;
                $display("FAIL unexpected_beat: got data=%h keep=%b last=%b user=%b at cycle %0d, expected no beat",
                         out_master_rx_tdata, out_master_rx_tkeep, out_master_rx_tlast, out_master_rx_tuser, cyc);
            end else begin
                e = exp_q.pop_front();
                for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{e.keep[i]}};
                if (((out_master_rx_tdata & m) !== (e.dat & m)) || (out_master_rx_tkeep !== e.keep) ||
                    (out_master_rx_tlast !== e.last) || (out_master_rx_tuser !== e.user) || (cyc != e.cyc)) begin
                    err_cnt++;
                    $display("FAIL beat: got data=%h keep=%b last=%b user=%b cyc=%0d, expected data=%h keep=%b last=%b user=%b cyc=%0d",
                             out_master_rx_tdata & m, out_master_rx_tkeep, out_master_rx_tlast, out_master_rx_tuser, cyc,
                             e.dat & m, e.keep, e.last, e.user, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] d, input logic [3:0] c);
        @(negedge rx_clk);
        in_xgmii_data = d;
        in_xgmii_ctl  = c;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(32'h07070707, 4'hF);
    endtask

    function automatic logic [31:0] eth_fcs(input bq_t b);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Payload of L bytes yields ceil(L/4) beats, each three cycles after its source word.
    task automatic send_frame(input bq_t pay, input bit bad_fcs, input int err_word, input bit bad_pre);
        bq_t         fr;
        logic [31:0] fcs, d;
        logic [3:0]  c;
        int          len, nw, k, e0, nb;
        beat_t       b;
        fr  = pay;
        len = pay.size();
        if (err_word >= 0) fr[4*err_word+2] = 8'hFE;
        fcs = eth_fcs(pay);
        if (bad_fcs) fcs = fcs ^ 32'h0000_0100;
        for (int i = 0; i < 4; i++) fr.push_back(fcs[8*i +: 8]);
        nw = (len + 4) / 4;
        k  = (len + 4) % 4;
        drive(32'h555555FB, 4'b0001);
        e0 = cyc + 1;
        nb = bad_pre ? 0 : (len + 3) / 4;
        for (int i = 0; i < nb; i++) begin
            for (int l = 0; l < 4; l++) b.dat[8*l +: 8] = fr[4*i+l];
            b.last = (i == nb - 1);
            b.keep = (b.last && (len % 4 != 0)) ? 4'((1 << (len % 4)) - 1) : 4'hF;
            b.user = b.last && (bad_fcs || err_word >= 0);
            b.cyc  = e0 + 2 + i + 3;
            exp_q.push_back(b);
        end
        drive(bad_pre ? 32'hD5555554 : 32'hD5555555, 4'b0000);
        for (int j = 0; j < nw; j++) begin
            for (int l = 0; l < 4; l++) d[8*l +: 8] = fr[4*j+l];
            drive(d, (j == err_word) ? 4'b0100 : 4'b0000);
        end
        for (int l = 0; l < 4; l++) begin
            if (l < k) begin
                d[8*l +: 8] = fr[4*nw+l];
                c[l] = 1'b0;
            end else begin
                d[8*l +: 8] = (l == k) ? 8'hFD : 8'h07;
                c[l] = 1'b1;
            end
        end
        drive(d, c);
    endtask

    function automatic bq_t ramp(input int n);
        bq_t p;
        for (int i = 0; i < n; i++) p.push_back(8'((i + 1) * 17));
        return p;
    endfunction

    initial begin
        tv_t   tv[11];
        bq_t   p;
        beat_t b;
        int    w0;

        //       len bad err pre beats keep   user
        tv[0]  = '{8,  0, -1, 0, 2, 4'hF, 1'b0};
        tv[1]  = '{5,  0, -1, 0, 2, 4'h1, 1'b0};
        tv[2]  = '{5,  1, -1, 0, 2, 4'h1, 1'b1};
        tv[3]  = '{8,  0, -1, 1, 0, 4'h0, 1'b0};
        tv[4]  = '{8,  0, -1, 0, 2, 4'hF, 1'b0};
        tv[5]  = '{12, 0,  1, 0, 3, 4'hF, 1'b1};
        tv[6]  = '{1,  0, -1, 0, 1, 4'h1, 1'b0};
        tv[7]  = '{0,  0, -1, 0, 0, 4'h0, 1'b0};
        tv[8]  = '{7,  0, -1, 0, 2, 4'h7, 1'b0};
        tv[9]  = '{4,  0, -1, 0, 1, 4'hF, 1'b0};
        tv[10] = '{3,  0, -1, 0, 1, 4'h7, 1'b0};

        rx_rst        = 1'b1;
        in_xgmii_data = 32'h07070707;
        in_xgmii_ctl  = 4'hF;
        repeat (3) @(negedge rx_clk);
        chk("rst_tvalid", {31'h0, out_master_rx_tvalid}, 32'h0);
        chk("rst_tlast",  {31'h0, out_master_rx_tlast},  32'h0);
        chk("rst_tuser",  {31'h0, out_master_rx_tuser},  32'h0);
        chk("rst_tkeep",  {28'h0, out_master_rx_tkeep},  32'h0);
        chk("rst_tdata",  out_master_rx_tdata,           32'h0);
        rx_rst = 1'b0;
        idle(3);

        for (int t = 0; t < 11; t++) begin
            beats_seen     = 0;
            last_keep_seen = '0;
            last_user_seen = 1'b0;
            send_frame(ramp(tv[t].len), tv[t].bad_fcs, tv[t].err_word, tv[t].bad_pre);
            idle(8);
            chk($sformatf("tv%0d_beats", t), beats_seen, tv[t].exp_beats);
            if (tv[t].exp_beats > 0) begin
                chk($sformatf("tv%0d_keep", t), {28'h0, last_keep_seen}, {28'h0, tv[t].exp_keep});
                chk($sformatf("tv%0d_user", t), {31'h0, last_user_seen}, {31'h0, tv[t].exp_user});
            end
        end

        // Back-to-back: second start directly follows the first terminate.
        beats_seen = 0;
        send_frame(ramp(9), 1'b0, -1, 1'b0);
        send_frame(ramp(6), 1'b0, -1, 1'b0);
        idle(8);
        chk("b2b_beats", beats_seen, 5);

        // Reset while the first beat of a frame is on the outputs.
        beats_seen = 0;
        drive(32'h555555FB, 4'b0001);
        drive(32'hD5555555, 4'b0000);
        drive(32'hA3A2A1A0, 4'b0000);
        w0 = cyc + 1;
        b = '{32'hA3A2A1A0, 4'hF, 1'b0, 1'b0, w0 + 3};
        exp_q.push_back(b);
        drive(32'hB3B2B1B0, 4'b0000);
        drive(32'hC3C2C1C0, 4'b0000);
        drive(32'hD3D2D1D0, 4'b0000);
        @(negedge rx_clk);
        #2;
        rx_rst        = 1'b1;
        in_xgmii_data = 32'h07070707;
        in_xgmii_ctl  = 4'hF;
        #1;
        chk("midrst_tvalid", {31'h0, out_master_rx_tvalid}, 32'h0);
        chk("midrst_tdata",  out_master_rx_tdata, 32'h0);
        repeat (2) @(negedge rx_clk);
        rx_rst = 1'b0;
        idle(4);
        chk("midrst_beats", beats_seen, 1);
        send_frame(ramp(9), 1'b0, -1, 1'b0);
        idle(8);
        chk("postrst_beats", beats_seen, 4);

        for (int r = 0; r < 25; r++) begin
            p.delete();
            for (int i = 0, n = $urandom_range(0, 30); i < n; i++) p.push_back(8'($urandom));
            send_frame(p, ($urandom_range(0, 3) == 0), -1, 1'b0);
            idle($urandom_range(0, 3));
        end
        idle(10);

        vec_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL missing_beats: got %0d beats still outstanding, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/rx_mac.md
RX_MAC -- requirements
Module: rx_mac

Interface
REQ-001 SHALL have parameters: XGMII_DATA_WIDTH, default 32, XGMII data width; XGMII_DATA_BYTES, default 4, XGMII lanes; AXIS_DATA_WIDTH, default 32, AXIS data width; AXIS_DATA_BYTES, default 4, AXIS tkeep width.
REQ-002 SHALL have ports:
- rx_clk  in  1  sole clock; all logic on rising edge.
- rx_rst  in  1  asynchronous, active-high reset.
- in_xgmii_data  in  32  XGMII receive data; lane i = bits [8i+7:8i]; lane 0 is first on the wire.
- in_xgmii_ctl  in  4  per-lane control flag; 1 = control character.
- out_master_rx_tdata  out  32  payload bytes, same lane order as XGMII.
- out_master_rx_tkeep  out  4  valid-byte mask, contiguous from lane 0.
- out_master_rx_tvalid  out  1  beat valid.
- out_master_rx_tlast  out  1  last beat of frame.
- out_master_rx_tuser  out  1  frame error; meaningful only with tlast.
REQ-003 SHALL provide no tready input: the AXIS output has no backpressure, and the consumer SHALL accept every beat.

Function
REQ-004 Control codes SHALL be: start 0xFB, terminate 0xFD, error 0xFE, idle 0x07.
REQ-005 SHALL use states IDLE, PREAMBLE, DATA and DROP.
REQ-006 IDLE -> PREAMBLE when ctl[0]=1, lane0=0xFB, ctl[3:1]=0, and lanes 1-3 = 0x55; start in any other lane SHALL be ignored.
REQ-007 PREAMBLE: next word SHALL be ctl=0000, data 0xD5555555 (lanes 0-2 = 0x55, lane 3 = 0xD5) -> DATA. Otherwise -> DROP.
REQ-008 DROP: no output; SHALL return to IDLE on any word containing 0xFD or 0x07 with its ctl bit set.
REQ-009 DATA: each word with ctl=0000 is frame data and SHALL enter a 2-deep word shift register.
REQ-010 Terminate in lane k (lowest lane with ctl=1 and data 0xFD) SHALL end the frame; lanes below k are frame data.
REQ-011 The last 4 frame bytes before terminate are FCS and SHALL NOT be output.
- k=0: last payload beat = word two before the terminate word, tkeep=1111.
- k=1..3: last payload beat = word immediately before the terminate word, tkeep=(1<<k)-1.
REQ-012 Non-last beats SHALL have tkeep=1111, tlast=0 and tuser=0.
REQ-013 Latency SHALL be fixed: a payload word sampled at edge n is presented on the outputs after edge n+3. tvalid SHALL be high for exactly one cycle per beat.
REQ-014 CRC-32 (reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF, no final XOR in the register) SHALL run over all frame bytes after the SFD, including FCS. At terminate, register value != 0xDEBB20E3 SHALL set tuser on the tlast beat.
REQ-015 Any control lane in DATA other than terminate (e.g. 0xFE in any lane) SHALL latch an error flag. Reception SHALL continue until terminate, then tuser=1 on the tlast beat. The flag SHALL clear at the next start.
REQ-016 Frames with fewer than 5 data bytes before terminate (zero payload) SHALL produce no beats and return to IDLE.
REQ-017 A start character seen in DATA SHALL end the current frame: last buffered word is emitted with tlast=1, tuser=1, tkeep=1111, nothing stripped. The new start word is then handled as in IDLE.
REQ-018 After terminate the block SHALL return to IDLE. A start in the cycle directly after the terminate word SHALL be accepted, and back-to-back frames SHALL NOT lose beats.
REQ-019 CRC update SHALL be 4 bytes per cycle for full words, with a k-byte partial update on the terminate word.

Reset
REQ-020 While rx_rst=1, state SHALL be IDLE, shift register and CRC cleared, and all outputs 0. This SHALL hold asynchronously on assertion.
REQ-021 Reset asserted mid-frame SHALL discard the frame with no tlast emitted. After release the block SHALL wait for a fresh start.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Good 8-byte frame: FB555555, D5555555, 0x44332211, 0x88776655, 4 correct FCS bytes, then FD in lane 0 -> two beats 0x44332211/1111 and 0x88776655/1111 with tlast, tuser=0; first beat 3 cycles after its input.
- Good 5-byte payload, FD in lane 1 -> beats 1111 then 0001 with tlast, tuser=0.
- Same frame with one FCS bit flipped -> identical beats, tuser=1 on the tlast beat.
- Preamble word 2 = 0xD5555554 -> no output; next good frame is received normally.
- 0xFE with ctl set in lane 2 mid-payload -> frame completes, tuser=1 on tlast; 1-byte payload frame -> single beat, tkeep 0001, tlast=1; zero-payload frame -> no beats.
- Back-to-back frames with start immediately after terminate -> all beats of both frames correct. rx_rst pulsed mid-frame -> outputs 0 immediately, no tlast, following frame correct.
